// File: rtl/bit_serializer.sv
// bit_serializer
// Parallel-to-serial front end for the sequence detector. Words of WIDTH
// bits are accepted over a valid/ready handshake and shifted out one bit per
// clock on dout. A word accepted on the final bit cycle follows with no gap.
//
// Optional feature macro: BIT_SERIALIZER_PARITY_EN. When it is defined, each
// word is followed by one even-parity bit (XOR of the data bits).
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-low reset
//   in_data    : word to serialize, sampled on acceptance
//   in_valid   : in_data is valid
//   in_ready   : a word can be accepted this cycle (0 while rst is low)
//   dout       : serial bit to the detector din
//   dout_valid : dout carries a payload or parity bit
//   word_done  : pulse on the final bit of each word
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;
  logic             head_s;
  logic [WIDTH-1:0] shifted_s;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // State, shift register and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Handshake, output decode and next-state logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    last_s    = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
    head_s    = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    shifted_s = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

    // in_ready depends only on registered state and rst, never on in_valid
    case (state_q)
      S_IDLE:   ready_s = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      S_SHIFT:  ready_s = 1'b0;
      S_PARITY: ready_s = 1'b1;
`else
      S_SHIFT:  ready_s = last_s;
`endif
      default:  ready_s = 1'b0;
    endcase
    in_ready = rst & ready_s;
    accept_s = in_valid & in_ready;

    // Outputs decoded from registered state only
    case (state_q)
      S_SHIFT: begin
        dout       = head_s;
        dout_valid = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        word_done  = 1'b0;
`else
        word_done  = last_s;
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: begin
        dout       = parity_q;
        dout_valid = 1'b1;
        word_done  = 1'b1;
      end
`endif
      default: begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        word_done  = 1'b0;
      end
    endcase

    // A word ends either on its last payload bit or on its parity bit; both
    // paths reload directly from in_data to keep the stream gapless.
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_SHIFT;
          shreg_d = in_data;
          cnt_d   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
          parity_d = ^in_data;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!last_s) begin
          shreg_d = shifted_s;
          cnt_d   = cnt_q + CW'(1);
`ifdef BIT_SERIALIZER_PARITY_EN
        end else begin
          // Counter parks at the last value until the next load
          state_d = S_PARITY;
          shreg_d = shifted_s;
        end
`else
        end else if (accept_s) begin
          state_d = S_SHIFT;
          shreg_d = in_data;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: begin
        if (accept_s) begin
          state_d  = S_SHIFT;
          shreg_d  = in_data;
          cnt_d    = '0;
          parity_d = ^in_data;
        end else begin
          state_d  = S_IDLE;
          shreg_d  = '0;
          cnt_d    = '0;
          parity_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: queue-based reference of the expected bit
// stream, a per-cycle compare process, directed literal checks and a
// randomized handshake phase with occasional asynchronous resets.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WLEN = W + PAR;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, dout, dout_valid, word_done;

  logic [W-1:0] in_data2 = '0;
  logic         in_valid2 = 1'b0;
  logic         in_ready2, dout2, dout_valid2, word_done2;

  int vectors = 0;
  int miscompares = 0;

  // Expected bit stream: front entry is the bit on dout this cycle
  bit exp_q[$];
  bit acc_last = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
    .word_done(word_done)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .dout(dout2), .dout_valid(dout_valid2),
    .word_done(word_done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) exp_q.push_back(w[W-1-i]);
    if (PAR != 0) exp_q.push_back(^w);
  endtask

  // Reference model: a word can enter when at most one bit remains queued
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      acc = in_valid && (exp_q.size() <= 1);
      if (exp_q.size() > 0) exp_q.delete(0);
      if (acc) push_word(in_data);
      acc_last = acc;
    end else begin
      acc_last = 1'b0;
    end
  end

  always @(negedge rst) exp_q.delete();

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_dout", {31'd0, dout}, 32'd0);
      check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
      check("rst_word_done", {31'd0, word_done}, 32'd0);
      check("rst_lsb_valid", {31'd0, dout_valid2}, 32'd0);
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() <= 1});
      check("dout_valid", {31'd0, dout_valid}, {31'd0, exp_q.size() > 0});
      check("dout", {31'd0, dout}, {31'd0, (exp_q.size() > 0) ? exp_q[0] : 1'b0});
      check("word_done", {31'd0, word_done}, {31'd0, exp_q.size() == 1});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, exp_q.size() != 0}, 32'd0);
  endtask

  logic [31:0] cap;
  int          wd;
  int          rdy;
  int          hits;
  int          n;
  bit          sb[64];

  initial begin
    // Reset state
    #2;
    check("por_in_ready", {31'd0, in_ready}, 32'd0);
    check("por_dout_valid", {31'd0, dout_valid}, 32'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("release_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Single word 8'hB6, MSB first
    wait_idle();
    in_data  = 8'hB6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cap = 32'd0;
    wd  = 0;
    for (int i = 0; i < WLEN; i++) begin
      check("b6_valid", {31'd0, dout_valid}, 32'd1);
      cap = (cap << 1) | {31'd0, dout};
      wd += int'(word_done);
      if (i == WLEN - 1) check("b6_word_done_last", {31'd0, word_done}, 32'd1);
      step();
    end
    check("b6_stream", cap, (PAR != 0) ? 32'h16D : 32'h0B6);
    check("b6_done_count", wd, 32'd1);
    check("b6_idle_after", {31'd0, dout_valid}, 32'd0);

    // LSB-first 8'h01 on the second instance
    in_data2  = 8'h01;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    cap = 32'd0;
    check("lsb_first_bit", {31'd0, dout2}, 32'd1);
    for (int i = 0; i < WLEN; i++) begin
      check("lsb_valid", {31'd0, dout_valid2}, 32'd1);
      cap = cap | ({31'd0, dout2} << i);
      step();
    end
    check("lsb_stream", cap, (PAR != 0) ? 32'h101 : 32'h001);
    check("lsb_idle_after", {31'd0, dout_valid2}, 32'd0);

    // Back-to-back 8'hB0 then 8'h58 with in_valid held
    wait_idle();
    in_data  = 8'hB0;
    in_valid = 1'b1;
    step();
    in_data = 8'h58;
    cap = 32'd0;
    rdy = 0;
    for (int i = 0; i < 2 * WLEN; i++) begin
      sb[i] = dout;
      cap = (cap << 1) | {31'd0, dout};
      check("b2b_valid", {31'd0, dout_valid}, 32'd1);
      if (i < 2 * WLEN - 1) rdy += int'(in_ready);
      step();
      if (acc_last) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_stream", cap, (PAR != 0) ? 32'h2C2B1 : 32'hB058);
    check("b2b_ready_count", rdy, 32'd1);
    hits = 0;
    for (int i = 0; i + 4 < 2 * WLEN; i++)
      if (sb[i] && !sb[i+1] && sb[i+2] && sb[i+3] && !sb[i+4]) hits++;
    check("b2b_pattern_hits", hits, 32'd2);

    // Backpressure: 8'hFF offered after three bits of 8'hAA
    wait_idle();
    in_data  = 8'hAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_last && n < 20);
    in_valid = 1'b0;
    check("bp_accept_delay", n, W - 2 + PAR);
    check("bp_first_bit", {31'd0, dout}, 32'd1);
    check("bp_first_valid", {31'd0, dout_valid}, 32'd1);

    // Reset mid-word after three bits of 8'hAA
    wait_idle();
    in_data  = 8'hAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("arst_dout", {31'd0, dout}, 32'd0);
    check("arst_valid", {31'd0, dout_valid}, 32'd0);
    check("arst_done", {31'd0, word_done}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("arst_release_ready", {31'd0, in_ready}, 32'd1);
    in_data  = 8'hC3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cap = 32'd0;
    for (int i = 0; i < WLEN; i++) begin
      cap = (cap << 1) | {31'd0, dout};
      step();
    end
    check("arst_c3_stream", cap, (PAR != 0) ? 32'h186 : 32'h0C3);

    // Randomized handshake with rare resets
    for (int c = 0; c < 3000; c++) begin
      if (in_valid && !acc_last && ($urandom % 8 != 0)) begin
        in_valid = 1'b1;
      end else begin
        in_valid = ($urandom % 3) != 0;
        in_data  = W'($urandom);
      end
      if ($urandom % 400 == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    wait_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
